ddr_a2m_wr_errchk: RTL and testbench

- Registered AXI write-request checker placed in front of the AXI-to-MBA write path.
- Legality is checked against parametrised limits: size, burst type, length, WRAP length, 4KB crossing.
- Legal bursts are forwarded downstream. Illegal bursts are absorbed: their W beats are drained locally and one SLVERR B response is generated, kept in order with outstanding legal responses.

---
 rtl/ddr_a2m_wr_errchk.sv | 188 ++++++++++++++++++
 tb/tb_ddr_a2m_wr_errchk.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_a2m_wr_errchk.sv
// AXI write-request legality checker in front of the AXI-to-MBA write path.
// Legal bursts pass through; illegal bursts are drained locally and answered with an in-order SLVERR.
module ddr_a2m_wr_errchk #(
  parameter int unsigned ID_W        = 8,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned MAX_LEN     = 255,
  parameter int unsigned ALLOW_FIXED = 0,
  parameter int unsigned CHK_4K      = 1,
  parameter int unsigned RFIFO_DEPTH = 4,
  parameter int unsigned OUTST_W     = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [ID_W-1:0]       S_AWID,
  input  logic [ADDR_W-1:0]     S_AWADDR,
  input  logic [7:0]            S_AWLEN,
  input  logic [2:0]            S_AWSIZE,
  input  logic [1:0]            S_AWBURST,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [ID_W-1:0]       M_AWID,
  output logic [ADDR_W-1:0]     M_AWADDR,
  output logic [7:0]            M_AWLEN,
  output logic [2:0]            M_AWSIZE,
  output logic [1:0]            M_AWBURST,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  input  logic [DATA_W-1:0]     S_WDATA,
  input  logic [DATA_W/8-1:0]   S_WSTRB,
  input  logic                  S_WLAST,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  output logic [DATA_W-1:0]     M_WDATA,
  output logic [DATA_W/8-1:0]   M_WSTRB,
  output logic                  M_WLAST,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  input  logic [ID_W-1:0]       M_BID,
  input  logic [1:0]            M_BRESP,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  output logic [ID_W-1:0]       S_BID,
  output logic [1:0]            S_BRESP,
  output logic                  ERR_PULSE,
  output logic [4:0]            ERR_CODE
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_W / 8);
  localparam int unsigned PTR_W    = $clog2(RFIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_WAITB = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [OUTST_W-1:0] outst_q;
  logic [ID_W-1:0]    err_id_q;
  logic [RFIFO_DEPTH-1:0] rf_q;
  logic [PTR_W:0]     rf_wr_q, rf_rd_q;

  logic size_err, burst_err, len_err, wrap_err, bound_err, aw_err;
  logic [13:0] addr_lo, span_bytes, span_end;
  logic rf_empty, rf_full, head_err;
  logic aw_hs, w_pop, b_hs, cnt_inc;

  // Request legality, evaluated on the live AW payload
  always_comb begin
    addr_lo    = 14'(S_AWADDR[11:0]) & ~((14'(1) << S_AWSIZE) - 14'(1));
    span_bytes = (14'(S_AWLEN) + 14'(1)) << S_AWSIZE;
    span_end   = addr_lo + span_bytes;
    size_err   = 32'(S_AWSIZE) > MAX_SIZE;
    burst_err  = (S_AWBURST == 2'b11) || ((S_AWBURST == BURST_FIXED) && (ALLOW_FIXED == 0));
    len_err    = 32'(S_AWLEN) > MAX_LEN;
    wrap_err   = (S_AWBURST == BURST_WRAP) &&
                 !((S_AWLEN == 8'd1) || (S_AWLEN == 8'd3) || (S_AWLEN == 8'd7) || (S_AWLEN == 8'd15));
    bound_err  = (CHK_4K != 0) && (S_AWBURST == BURST_INCR) && (span_end > 14'd4096);
    aw_err     = size_err | burst_err | len_err | wrap_err | bound_err;
  end

  assign rf_empty = (rf_wr_q == rf_rd_q);
  assign rf_full  = (rf_wr_q[PTR_W] != rf_rd_q[PTR_W]) &&
                    (rf_wr_q[PTR_W-1:0] == rf_rd_q[PTR_W-1:0]);
  assign head_err = rf_q[rf_rd_q[PTR_W-1:0]];

  assign S_AWREADY = (state_q == ST_IDLE) && !rf_full && (outst_q != {OUTST_W{1'b1}}) &&
                     (!M_AWVALID || M_AWREADY);
  assign aw_hs     = S_AWVALID && S_AWREADY;
  assign cnt_inc   = aw_hs && !aw_err;

  // W routing follows the legality of the oldest accepted burst
  assign S_WREADY = !rf_empty && (head_err || M_WREADY);
  assign M_WVALID = !rf_empty && !head_err && S_WVALID;
  assign M_WDATA  = S_WDATA;
  assign M_WSTRB  = S_WSTRB;
  assign M_WLAST  = S_WLAST;
  assign w_pop    = S_WVALID && S_WREADY && S_WLAST;

  assign b_hs = M_BVALID && M_BREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rf_q    <= '0;
      rf_wr_q <= '0;
      rf_rd_q <= '0;
    end else begin
      if (aw_hs) begin
        rf_q[rf_wr_q[PTR_W-1:0]] <= aw_err;
        rf_wr_q <= rf_wr_q + (PTR_W+1)'(1);
      end
      if (w_pop) rf_rd_q <= rf_rd_q + (PTR_W+1)'(1);
    end
  end

  // Downstream AW register: holds stable until accepted
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      M_AWVALID <= 1'b0;
      M_AWID    <= '0;
      M_AWADDR  <= '0;
      M_AWLEN   <= '0;
      M_AWSIZE  <= '0;
      M_AWBURST <= '0;
    end else if (cnt_inc) begin
      M_AWVALID <= 1'b1;
      M_AWID    <= S_AWID;
      M_AWADDR  <= S_AWADDR;
      M_AWLEN   <= S_AWLEN;
      M_AWSIZE  <= S_AWSIZE;
      M_AWBURST <= S_AWBURST;
    end else if (M_AWREADY) begin
      M_AWVALID <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      outst_q   <= '0;
      err_id_q  <= '0;
      ERR_PULSE <= 1'b0;
      ERR_CODE  <= '0;
    end else begin
      if (cnt_inc && !b_hs)      outst_q <= outst_q + OUTST_W'(1);
      else if (!cnt_inc && b_hs) outst_q <= outst_q - OUTST_W'(1);
      ERR_PULSE <= aw_hs && aw_err;
      if (aw_hs && aw_err) begin
        err_id_q <= S_AWID;
        ERR_CODE <= {bound_err, wrap_err, len_err, burst_err, size_err};
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and B-channel muxing; the error response waits for all older legal B's
  always_comb begin
    state_d  = state_q;
    S_BVALID = M_BVALID;
    S_BID    = M_BID;
    S_BRESP  = M_BRESP;
    M_BREADY = S_BREADY;
    case (state_q)
      ST_IDLE:  if (aw_hs && aw_err) state_d = ST_DRAIN;
      ST_DRAIN: if (w_pop && head_err) state_d = ST_WAITB;
      ST_WAITB: if (outst_q == '0) state_d = ST_RESP;
      ST_RESP: begin
        S_BVALID = 1'b1;
        S_BID    = err_id_q;
        S_BRESP  = RESP_SLVERR;
        M_BREADY = 1'b0;
        if (S_BREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr_a2m_wr_errchk.sv
// Directed bench for ddr_a2m_wr_errchk: legal pass-through, each rejection class,
// response ordering, FIFO/counter back-pressure and mid-drain reset.
module tb_ddr_a2m_wr_errchk;

  logic ACLK, ARESETN;
  logic S_AWVALID, S_AWREADY, M_AWVALID, M_AWREADY;
  logic [7:0]  S_AWID, M_AWID;
  logic [31:0] S_AWADDR, M_AWADDR;
  logic [7:0]  S_AWLEN, M_AWLEN;
  logic [2:0]  S_AWSIZE, M_AWSIZE;
  logic [1:0]  S_AWBURST, M_AWBURST;
  logic S_WVALID, S_WREADY, S_WLAST, M_WVALID, M_WREADY, M_WLAST;
  logic [127:0] S_WDATA, M_WDATA;
  logic [15:0]  S_WSTRB, M_WSTRB;
  logic M_BVALID, M_BREADY, S_BVALID, S_BREADY;
  logic [7:0] M_BID, S_BID;
  logic [1:0] M_BRESP, S_BRESP;
  logic ERR_PULSE;
  logic [4:0] ERR_CODE;

  // Second instance with the 4KB check disabled; only its AW channel is exercised
  logic a2_awvalid, a2_awready, a2_m_awvalid;
  logic [7:0]  a2_m_awid, a2_m_awlen;
  logic [31:0] a2_m_awaddr;
  logic [2:0]  a2_m_awsize;
  logic [1:0]  a2_m_awburst;
  logic a2_s_wready, a2_m_wvalid, a2_m_wlast, a2_m_bready, a2_s_bvalid, a2_err_pulse;
  logic [127:0] a2_m_wdata;
  logic [15:0]  a2_m_wstrb;
  logic [7:0]   a2_s_bid;
  logic [1:0]   a2_s_bresp;
  logic [4:0]   a2_err_code;

  int errors = 0;
  int checks = 0;

  ddr_a2m_wr_errchk u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWID(S_AWID), .S_AWADDR(S_AWADDR),
    .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWID(M_AWID), .M_AWADDR(M_AWADDR),
    .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BID(M_BID), .M_BRESP(M_BRESP),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BID(S_BID), .S_BRESP(S_BRESP),
    .ERR_PULSE(ERR_PULSE), .ERR_CODE(ERR_CODE)
  );

  ddr_a2m_wr_errchk #(.CHK_4K(0)) u_dut_no4k (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWVALID(a2_awvalid), .S_AWREADY(a2_awready), .S_AWID(8'h33), .S_AWADDR(32'h0000_0FF0),
    .S_AWLEN(8'd1), .S_AWSIZE(3'd4), .S_AWBURST(2'b01),
    .M_AWVALID(a2_m_awvalid), .M_AWREADY(1'b0), .M_AWID(a2_m_awid), .M_AWADDR(a2_m_awaddr),
    .M_AWLEN(a2_m_awlen), .M_AWSIZE(a2_m_awsize), .M_AWBURST(a2_m_awburst),
    .S_WVALID(1'b0), .S_WREADY(a2_s_wready), .S_WDATA('0), .S_WSTRB('0), .S_WLAST(1'b0),
    .M_WVALID(a2_m_wvalid), .M_WREADY(1'b0), .M_WDATA(a2_m_wdata), .M_WSTRB(a2_m_wstrb), .M_WLAST(a2_m_wlast),
    .M_BVALID(1'b0), .M_BREADY(a2_m_bready), .M_BID(8'h00), .M_BRESP(2'b00),
    .S_BVALID(a2_s_bvalid), .S_BREADY(1'b0), .S_BID(a2_s_bid), .S_BRESP(a2_s_bresp),
    .ERR_PULSE(a2_err_pulse), .ERR_CODE(a2_err_code)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Present one AW, wait (bounded) for acceptance; returns just after the accepting edge
  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    S_AWVALID = 1'b1; S_AWID = id; S_AWADDR = addr; S_AWLEN = len; S_AWSIZE = size; S_AWBURST = burst;
    for (int n = 0; n < 20; n++) begin
      @(negedge ACLK);
      if (S_AWREADY) begin ok = 1'b1; break; end
    end
    chk("aw_accept", 64'(ok), 64'd1);
    tick();
    S_AWVALID = 1'b0;
  endtask

  // Present one W beat, check whether it is forwarded downstream
  task automatic w_beat(input logic [127:0] data, input logic last, input logic exp_fwd);
    logic ok;
    ok = 1'b0;
    S_WVALID = 1'b1; S_WDATA = data; S_WSTRB = 16'hFFFF; S_WLAST = last;
    for (int n = 0; n < 20; n++) begin
      @(negedge ACLK);
      if (S_WREADY) begin ok = 1'b1; break; end
    end
    chk("w_accept", 64'(ok), 64'd1);
    chk("w_fwd_valid", 64'(M_WVALID), 64'(exp_fwd));
    if (exp_fwd) begin
      chk("w_fwd_data", M_WDATA[63:0], data[63:0]);
      chk("w_fwd_last", 64'(M_WLAST), 64'(last));
    end
    tick();
    S_WVALID = 1'b0; S_WLAST = 1'b0;
  endtask

  task automatic wait_sbvalid();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge ACLK);
      if (S_BVALID) begin ok = 1'b1; break; end
    end
    chk("b_wait", 64'(ok), 64'd1);
  endtask

  task automatic down_b(input logic [7:0] id);
    M_BVALID = 1'b1; M_BID = id; M_BRESP = 2'b00; S_BREADY = 1'b1;
    #1;
    chk("b_pass_valid", 64'(S_BVALID), 64'd1);
    chk("b_pass_id", 64'(S_BID), 64'(id));
    chk("b_pass_resp", 64'(S_BRESP), 64'd0);
    chk("b_pass_mready", 64'(M_BREADY), 64'd1);
    tick();
    M_BVALID = 1'b0; S_BREADY = 1'b0;
  endtask

  // Error response: expect SLVERR with the given ID and M_BREADY held low
  task automatic err_b(input logic [7:0] id);
    wait_sbvalid();
    chk("errb_id", 64'(S_BID), 64'(id));
    chk("errb_resp", 64'(S_BRESP), 64'd2);
    S_BREADY = 1'b1;
    #1;
    chk("errb_mready", 64'(M_BREADY), 64'd0);
    tick();
    S_BREADY = 1'b0;
    #1;
    chk("errb_done", 64'(S_BVALID), 64'd0);
  endtask

  task automatic legal_first();
    aw_send(8'h05, 32'h0000_0100, 8'd3, 3'd4, 2'b01);
    chk("s1_mawvalid", 64'(M_AWVALID), 64'd1);
    chk("s1_mawid", 64'(M_AWID), 64'h05);
    chk("s1_mawaddr", 64'(M_AWADDR), 64'h100);
    chk("s1_mawlen", 64'(M_AWLEN), 64'd3);
    chk("s1_mawsize", 64'(M_AWSIZE), 64'd4);
    chk("s1_mawburst", 64'(M_AWBURST), 64'd1);
    chk("s1_errpulse", 64'(ERR_PULSE), 64'd0);
    M_AWREADY = 1'b1;
    tick();
    M_AWREADY = 1'b0;
    chk("s1_mawvalid_drop", 64'(M_AWVALID), 64'd0);
    M_WREADY = 1'b1;
    for (int i = 0; i < 4; i++) w_beat(128'(32'hA000 + i), (i == 3), 1'b1);
    chk("s1_wready_empty", 64'(S_WREADY), 64'd0);
    down_b(8'h05);
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AWVALID = 0; S_AWID = 0; S_AWADDR = 0; S_AWLEN = 0; S_AWSIZE = 0; S_AWBURST = 0;
    M_AWREADY = 0; S_WVALID = 0; S_WDATA = 0; S_WSTRB = 0; S_WLAST = 0; M_WREADY = 0;
    M_BVALID = 0; M_BID = 0; M_BRESP = 0; S_BREADY = 0; a2_awvalid = 0;
    repeat (3) tick();
    chk("rst_mawvalid", 64'(M_AWVALID), 64'd0);
    chk("rst_sbvalid", 64'(S_BVALID), 64'd0);
    chk("rst_errpulse", 64'(ERR_PULSE), 64'd0);
    chk("rst_errcode", 64'(ERR_CODE), 64'd0);
    chk("rst_wready", 64'(S_WREADY), 64'd0);
    ARESETN = 1'b1;
    tick();

    // Legal INCR forwarded
    legal_first();

    // Oversized AWSIZE rejected and drained
    aw_send(8'h12, 32'h0, 8'd1, 3'd5, 2'b01);
    chk("s2_mawvalid", 64'(M_AWVALID), 64'd0);
    chk("s2_errpulse", 64'(ERR_PULSE), 64'd1);
    chk("s2_errcode", 64'(ERR_CODE), 64'b00001);
    chk("s2_awready_drain", 64'(S_AWREADY), 64'd0);
    tick();
    chk("s2_errpulse_once", 64'(ERR_PULSE), 64'd0);
    M_WREADY = 1'b0;
    w_beat(128'h1, 1'b0, 1'b0);
    w_beat(128'h2, 1'b1, 1'b0);
    err_b(8'h12);

    // 4KB crossing: rejected here, forwarded by the unchecked instance
    a2_awvalid = 1'b1;
    #1;
    chk("s3b_awready", 64'(a2_awready), 64'd1);
    tick();
    a2_awvalid = 1'b0;
    chk("s3b_mawvalid", 64'(a2_m_awvalid), 64'd1);
    chk("s3b_mawaddr", 64'(a2_m_awaddr), 64'hFF0);
    chk("s3b_errpulse", 64'(a2_err_pulse), 64'd0);
    aw_send(8'h33, 32'h0000_0FF0, 8'd1, 3'd4, 2'b01);
    chk("s3_errcode", 64'(ERR_CODE), 64'b10000);
    chk("s3_mawvalid", 64'(M_AWVALID), 64'd0);
    w_beat(128'h3, 1'b0, 1'b0);
    w_beat(128'h4, 1'b1, 1'b0);
    err_b(8'h33);

    // Error response ordered behind an older legal response
    M_AWREADY = 1'b1;
    M_WREADY = 1'b1;
    aw_send(8'h01, 32'h0000_0200, 8'd0, 3'd4, 2'b01);
    aw_send(8'h02, 32'h0000_0300, 8'd0, 3'd4, 2'b00);
    chk("s4_errcode", 64'(ERR_CODE), 64'b00010);
    w_beat(128'h10, 1'b1, 1'b1);
    w_beat(128'h11, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      chk("s4_holdoff_bvalid", 64'(S_BVALID), 64'd0);
      chk("s4_holdoff_awready", 64'(S_AWREADY), 64'd0);
    end
    down_b(8'h01);
    err_b(8'h02);
    chk("s4_awready_back", 64'(S_AWREADY), 64'd1);

    // Route FIFO full, then outstanding-counter saturation
    for (int i = 0; i < 4; i++) aw_send(8'(8'h40 + i), 32'h0000_0400, 8'd0, 3'd4, 2'b01);
    chk("s5_fifo_full", 64'(S_AWREADY), 64'd0);
    w_beat(128'h20, 1'b1, 1'b1);
    chk("s5_fifo_pop", 64'(S_AWREADY), 64'd1);
    for (int i = 0; i < 11; i++) begin
      aw_send(8'(8'h50 + i), 32'h0000_0400, 8'd0, 3'd4, 2'b01);
      w_beat(128'(i), 1'b1, 1'b1);
    end
    chk("s5_cnt_sat", 64'(S_AWREADY), 64'd0);
    down_b(8'h40);
    chk("s5_cnt_release", 64'(S_AWREADY), 64'd1);

    // Reset while draining a WRAP-length error burst
    M_AWREADY = 1'b0;
    aw_send(8'h77, 32'h0, 8'd2, 3'd4, 2'b10);
    chk("s6_errcode", 64'(ERR_CODE), 64'b01000);
    S_WVALID = 1'b1;
    tick();
    ARESETN = 1'b0;
    #1;
    chk("s6_rst_errcode", 64'(ERR_CODE), 64'd0);
    chk("s6_rst_mawvalid", 64'(M_AWVALID), 64'd0);
    chk("s6_rst_sbvalid", 64'(S_BVALID), 64'd0);
    chk("s6_rst_wready", 64'(S_WREADY), 64'd0);
    chk("s6_rst_awready", 64'(S_AWREADY), 64'd1);
    S_WVALID = 1'b0;
    tick();
    ARESETN = 1'b1;
    tick();
    legal_first();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
